// File: rtl/rv32_id_stage.sv
// RV32 instruction-decode stage: valid/ready capture, 4-bit ALU op decode, 32x32 register file.
// Optional macro RV32_ID_BYPASS_EN forwards same-cycle writeback data instead of stalling.
module rv32_id_stage #(
    parameter int ZERO_REGS_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] reg_s1,
    output logic [31:0] reg_s2,
    output logic [31:0] pc,
    output logic [31:0] code_bus,
    output logic [3:0]  alu_opsel,
    output logic        enable,
    output logic        illegal
);

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        out_valid_q, out_valid_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  alu_opsel_q, alu_opsel_d;
    logic [31:0] reg_s1_q, reg_s1_d;
    logic [31:0] reg_s2_q, reg_s2_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] code_bus_q, code_bus_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [3:0]  dec_op;
    logic        dec_illegal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        wb_we;
    logic        capture;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign funct7  = in_instr[31:25];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];

    assign wb_we = wb_en & (wb_addr != 5'd0) & ~rst;

    always_comb begin
        dec_op      = 4'd0;
        dec_illegal = 1'b1;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_illegal = 1'b0;
                    case (funct3)
                        3'b000:  dec_op = 4'd0;
                        3'b111:  dec_op = 4'd2;
                        3'b110:  dec_op = 4'd3;
                        3'b100:  dec_op = 4'd4;
                        3'b010:  dec_op = 4'd5;
                        3'b011:  dec_op = 4'd6;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op      = 4'd1;
                    dec_illegal = 1'b0;
                end
            end
            7'b0010011: begin
                // Immediate shifts (funct3 001/101) fall through as illegal.
                dec_illegal = 1'b0;
                case (funct3)
                    3'b000:  dec_op = 4'd7;
                    3'b111:  dec_op = 4'd9;
                    3'b110:  dec_op = 4'd10;
                    3'b100:  dec_op = 4'd11;
                    3'b010:  dec_op = 4'd12;
                    3'b011:  dec_op = 4'd13;
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    dec_op      = 4'd8;
                    dec_illegal = 1'b0;
                end
            end
            7'b0110111: begin
                dec_op      = 4'd14;
                dec_illegal = 1'b0;
            end
            7'b0010111: begin
                dec_op      = 4'd15;
                dec_illegal = 1'b0;
            end
            default: begin
                dec_op      = 4'd0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rs1_idx != 5'd0) rs1_val = rf_q[rs1_idx];
        if (rs2_idx != 5'd0) rs2_val = rf_q[rs2_idx];
`ifdef RV32_ID_BYPASS_EN
        if (wb_we && wb_addr == rs1_idx) rs1_val = wb_data;
        if (wb_we && wb_addr == rs2_idx) rs2_val = wb_data;
`endif
    end

`ifdef RV32_ID_BYPASS_EN
    assign in_ready = ~out_valid_q | out_ready;
`else
    // Hold off capture while the operand it needs is being written this cycle.
    logic hazard;
    assign hazard   = wb_we & ((wb_addr == rs1_idx) | (wb_addr == rs2_idx));
    assign in_ready = (~out_valid_q | out_ready) & ~hazard;
`endif

    assign capture = in_valid & in_ready;

    always_comb begin
        rf_d = rf_q;
        if (wb_we) rf_d[wb_addr] = wb_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        alu_opsel_d = alu_opsel_q;
        reg_s1_d    = reg_s1_q;
        reg_s2_d    = reg_s2_q;
        pc_d        = pc_q;
        code_bus_d  = code_bus_q;
        if (capture) begin
            out_valid_d = 1'b1;
            illegal_d   = dec_illegal;
            alu_opsel_d = dec_illegal ? 4'd0 : dec_op;
            reg_s1_d    = dec_illegal ? 32'd0 : rs1_val;
            reg_s2_d    = dec_illegal ? 32'd0 : rs2_val;
            pc_d        = in_pc;
            code_bus_d  = in_instr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (ZERO_REGS_ON_RESET != 0) begin
                for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_opsel_q <= 4'd0;
            reg_s1_q    <= 32'd0;
            reg_s2_q    <= 32'd0;
            pc_q        <= 32'd0;
            code_bus_q  <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            alu_opsel_q <= alu_opsel_d;
            reg_s1_q    <= reg_s1_d;
            reg_s2_q    <= reg_s2_d;
            pc_q        <= pc_d;
            code_bus_q  <= code_bus_d;
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign alu_opsel = alu_opsel_q;
    assign reg_s1    = reg_s1_q;
    assign reg_s2    = reg_s2_q;
    assign pc        = pc_q;
    assign code_bus  = code_bus_q;
    assign enable    = out_valid_q & ~illegal_q;

endmodule
